// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the EX/MEM stage and a word-wide
// data RAM with registered reads. It handles byte, halfword and word requests.
// Sub-word stores are read-modify-write, sub-word loads are sign/zero-extended,
// and byte lanes are big-endian (offset 0 = bits 31:24).
//
// Optional build macro: MAU_RANGE_CHECK_EN
//   defined   - a request with byte-address bits above ADDR_W+1 set is an error
//   undefined - those bits are ignored and addresses alias modulo 2^(ADDR_W+2)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a request, req_ready=1
// RD     | word address on ram_addr, RAM read launched
// CAP    | ram_dout valid: extract load lane or merge sub-word store data
// WR     | ram_we=1 for one cycle with the full or merged word
// RESP   | rsp_valid=1 for one cycle, then back to IDLE

module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Request fields captured on the accept edge
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_err;

  // Result of the request: load data or word to be written
  logic [31:0]       r_rdata;
  logic [31:0]       r_din;

  logic              w_accept;
  logic              w_size_err;
  logic              w_align_err;
  logic              w_range_err;
  logic              w_req_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merge_word;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Request classification: illegal size, misalignment and optional range error
  assign w_size_err  = (req_size == 2'b11);
  assign w_align_err = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

`ifdef MAU_RANGE_CHECK_EN
  assign w_range_err = (req_addr[31:ADDR_W+2] != '0);
`else
  // Upper address bits deliberately dropped; the word index aliases.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign w_range_err      = 1'b0;
`endif

  assign w_req_err = w_size_err || w_align_err || w_range_err;

  // Lane extraction and extension of the captured RAM word for loads
  always_comb begin
    w_byte      = 8'h00;
    w_half      = 16'h0000;
    w_load_data = ram_dout;
    case (r_off)
      2'd0:    w_byte = ram_dout[31:24];
      2'd1:    w_byte = ram_dout[23:16];
      2'd2:    w_byte = ram_dout[15:8];
      default: w_byte = ram_dout[7:0];
    endcase
    w_half = r_off[1] ? ram_dout[15:0] : ram_dout[31:16];
    case (r_size)
      SZ_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = ram_dout;
    endcase
  end

  // Replace only the addressed lane of the captured word for sub-word stores
  always_comb begin
    w_merge_word = ram_dout;
    case (r_size)
      SZ_BYTE: begin
        case (r_off)
          2'd0:    w_merge_word[31:24] = r_wdata[7:0];
          2'd1:    w_merge_word[23:16] = r_wdata[7:0];
          2'd2:    w_merge_word[15:8]  = r_wdata[7:0];
          default: w_merge_word[7:0]   = r_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (r_off[1]) begin
          w_merge_word[15:0] = r_wdata[15:0];
        end else begin
          w_merge_word[31:16] = r_wdata[15:0];
        end
      end
      default: w_merge_word = r_wdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection; word stores skip the read, errors skip the RAM entirely
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = S_RESP;
          end else if (req_we && (req_size == SZ_WORD)) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD:    w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = r_we ? S_WR : S_RESP;
      S_WR:    w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latches, load result and write data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_off    <= 2'b00;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_din    <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_off    <= req_addr[1:0];
        r_waddr  <= req_addr[ADDR_W+1:2];
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
        r_rdata  <= '0;
        r_din    <= req_wdata;
      end else if (r_state == S_CAP) begin
        if (r_we) begin
          r_din <= w_merge_word;
        end else begin
          r_rdata <= w_load_data;
        end
      end
    end
  end

  // ram_we decodes straight from the state so an async reset removes it at once
  assign ram_we    = (r_state == S_WR);
  assign ram_addr  = r_waddr;
  assign ram_din   = r_din;
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = rsp_valid ? r_rdata : 32'h0000_0000;
  assign rsp_err   = rsp_valid && r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a registered-read word RAM around the DUT, and a
// byte-addressed big-endian reference memory that predicts every response.
`timescale 1ns/1ps

module tb_mem_access_unit;

  localparam int ADDR_W = 10;
  localparam int NBYTES = 4 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  logic [31:0] ram     [0:(1<<ADDR_W)-1];
  logic [7:0]  ref_mem [0:NBYTES-1];

  int          n_checks;
  int          n_errors;
  logic [31:0] last_rdata;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM with registered read
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx], ref_mem[4*idx+1], ref_mem[4*idx+2], ref_mem[4*idx+3]};
  endfunction

  // One request end to end; expectations come from the byte reference memory
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
    int          a;
    int          widx;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_rdata;
    logic [31:0] exp_din;
    logic [7:0]  b;
    logic [15:0] h;
    int          lat;
    int          wr;
    logic [31:0] waddr;
    logic [31:0] wdin;

    a    = int'(addr % NBYTES);
    widx = a / 4;
    exp_err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
`ifdef MAU_RANGE_CHECK_EN
    if ((addr / NBYTES) != 0) exp_err = 1'b1;
`endif
    exp_rdata = 32'h0;
    exp_din   = 32'h0;
    exp_wr    = 0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (we) begin
      case (sz)
        2'b00: ref_mem[a] = wd[7:0];
        2'b01: begin ref_mem[a] = wd[15:8]; ref_mem[a+1] = wd[7:0]; end
        default: begin
          ref_mem[a] = wd[31:24]; ref_mem[a+1] = wd[23:16];
          ref_mem[a+2] = wd[15:8]; ref_mem[a+3] = wd[7:0];
        end
      endcase
      exp_din = ref_word(widx);
      exp_lat = (sz == 2'b10) ? 2 : 4;
      exp_wr  = 1;
    end else begin
      exp_lat = 3;
      case (sz)
        2'b00: begin
          b = ref_mem[a];
          exp_rdata = sgn ? {{24{b[7]}}, b} : {24'h0, b};
        end
        2'b01: begin
          h = {ref_mem[a], ref_mem[a+1]};
          exp_rdata = sgn ? {{16{h[15]}}, h} : {16'h0, h};
        end
        default: exp_rdata = ref_word(widx);
      endcase
    end

    @(negedge clk);
    check("ready_before", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    lat = 0; wr = 0; waddr = 32'h0; wdin = 32'h0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lat++;
      if (ram_we) begin
        wr++;
        waddr = 32'(ram_addr);
        wdin  = ram_din;
      end
      if (rsp_valid) break;
    end
    check("rsp_seen", {31'h0, rsp_valid}, 32'h1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("wr_count", 32'(wr), 32'(exp_wr));
    if (exp_wr != 0) begin
      check("wr_addr", waddr, 32'(widx));
      check("wr_data", wdin, exp_din);
    end
    last_rdata = rsp_rdata;
    @(negedge clk);
    check("rsp_pulse", {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] up;
    n_checks = 0;
    n_errors = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      w = $urandom;
      ram[i] = w;
      ref_mem[4*i] = w[31:24]; ref_mem[4*i+1] = w[23:16];
      ref_mem[4*i+2] = w[15:8]; ref_mem[4*i+3] = w[7:0];
    end

    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_ram_we", {31'h0, ram_we}, 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_din", ram_din, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("tp1_word", last_rdata, 32'h11223344);
    // Byte store then word load
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("tp2_word", last_rdata, 32'h11AB3344);
    // Sub-word loads with extension
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    check("tp3_sbyte", last_rdata, 32'hFFFFFFAB);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check("tp3_ubyte", last_rdata, 32'h000000AB);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("tp3_half2", last_rdata, 32'h00003344);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    check("tp3_half0", last_rdata, 32'h000011AB);
    // Error requests
    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF);
    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF);
    check("tp4_ram", ram[4], 32'h11AB3344);

    // Reset during WR of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h000000CD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_state_we", {31'h0, ram_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_we_drop", {31'h0, ram_we}, 32'h0);
    check("rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    check("rst_ready_mid", {31'h0, req_ready}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ram_kept", ram[4], 32'h11AB3344);
    check("rst_ready_after", {31'h0, req_ready}, 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("rst_reload", last_rdata, 32'h11AB3344);

    // Out-of-range / aliased address
    do_req(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0);

    // Random traffic over a small window plus occasional high address bits
    for (int n = 0; n < 300; n++) begin
      up = ($urandom_range(0, 7) == 0) ? ($urandom & ~32'(NBYTES - 1)) : 32'h0;
      do_req(1'($urandom), 2'($urandom), 1'($urandom),
             up | 32'($urandom_range(0, 63)), $urandom);
    end

    for (int i = 0; i < 16; i++) check("ram_image", ram[i], ref_word(i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
